stage3: RTL and testbench

- Third evaluation stage of the GE pipeline. Directly downstream of stage2: consumes its pass2/bonus2 results together with a fresh effort/hard/random sample.
- Runs a final exam with a bounded number of timed retries, then presents pass3, grade and attempt count.
- Uses a valid/ready handshake on both sides so it can stall behind slower consumers.

---
 rtl/stage3.sv | 197 +++++++++++++++++++
 tb/tb_stage3.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage3.sv
`default_nettype none
// ============================================================================
// Module   : stage3
// Brief    : Final-exam stage of the GE pipeline. Runs bounded, timed retries
//            and presents pass3/grade/attempts/score over valid/ready.
//            Optional feature macro: STAGE3_BURNOUT_EN (forced-fail burnout).
// Revision : 1.0 - initial release
// ============================================================================
module stage3 #(
  parameter int PASS_TH    = 75,
  parameter int MAX_RETRY  = 2,
  parameter int RETRY_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       pass2,
  input  logic [1:0] bonus2,
  input  logic [6:0] effort,
  input  logic [4:0] hard,
  input  logic [6:0] random3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pass3,
  output logic [1:0] grade,
  output logic [1:0] attempts,
  output logic [6:0] score
);

  localparam int            WW          = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST   = WW'(RETRY_WAIT - 1);
  localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRY);
  localparam logic [6:0]    PASS_LEVEL  = 7'(PASS_TH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_RETRY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    effort_q, effort_d;
  logic [1:0]    bonus_q, bonus_d;
  logic [4:0]    hard_q, hard_d;
  logic [3:0]    boost_q, boost_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          pass3_q, pass3_d;
  logic [1:0]    grade_q, grade_d;
  logic [1:0]    attempts_q, attempts_d;
  logic [6:0]    score_q, score_d;

  logic signed [8:0] raw;
  logic [6:0]        eval_score;
  logic [7:0]        boosted;
  logic              eval_pass;
  logic              burnout;
  logic              unused_bits;

  function automatic logic [1:0] grade_of(input logic [6:0] s);
    if (s > 7'd94)      return 2'd3;
    else if (s > 7'd87) return 2'd2;
    else if (s > 7'd80) return 2'd1;
    else                return 2'd0;
  endfunction

`ifdef STAGE3_BURNOUT_EN
  assign burnout     = (effort_q > 7'd100) && (random3[6:5] == 2'b00);
  assign unused_bits = ^random3[4:3];
`else
  assign burnout     = 1'b0;
  assign unused_bits = ^random3[6:3];
`endif

  always_comb begin
    raw = $signed({2'b00, effort_q}) + $signed({5'b00000, bonus_q, 2'b00})
        - $signed({4'b0000, hard_q});
    if (raw[8])      eval_score = 7'd0;
    else if (raw[7]) eval_score = 7'd127;
    else             eval_score = raw[6:0];
    eval_pass = (eval_score >= PASS_LEVEL);
    boosted   = {1'b0, effort_q} + {4'b0000, boost_q};
  end

  always_comb begin
    state_d     = state_q;
    effort_d    = effort_q;
    bonus_d     = bonus_q;
    hard_d      = hard_q;
    boost_d     = boost_q;
    wait_d      = wait_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    pass3_d     = pass3_q;
    grade_d     = grade_q;
    attempts_d  = attempts_q;
    score_d     = score_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          effort_d   = effort;
          bonus_d    = bonus2;
          hard_d     = hard;
          attempts_d = 2'd0;
          score_d    = 7'd0;
          pass3_d    = 1'b0;
          grade_d    = 2'd0;
          in_ready_d = 1'b0;
          if (!pass2) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        score_d = eval_score;
        // Burnout wins over a passing score and never earns a retry.
        if (burnout || (!eval_pass && attempts_q >= RETRY_LIMIT)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          pass3_d     = 1'b0;
          grade_d     = 2'd0;
        end else if (eval_pass) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          pass3_d     = 1'b1;
          grade_d     = grade_of(eval_score);
        end else begin
          state_d = S_RETRY;
          boost_d = {1'b0, random3[2:0]} + 4'd1;
          wait_d  = '0;
        end
      end
      S_RETRY: begin
        if (wait_q == WAIT_LAST) begin
          effort_d   = boosted[7] ? 7'd127 : boosted[6:0];
          attempts_d = attempts_q + 2'd1;
          state_d    = S_EVAL;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      effort_q    <= 7'd0;
      bonus_q     <= 2'd0;
      hard_q      <= 5'd0;
      boost_q     <= 4'd0;
      wait_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      pass3_q     <= 1'b0;
      grade_q     <= 2'd0;
      attempts_q  <= 2'd0;
      score_q     <= 7'd0;
    end else begin
      state_q     <= state_d;
      effort_q    <= effort_d;
      bonus_q     <= bonus_d;
      hard_q      <= hard_d;
      boost_q     <= boost_d;
      wait_q      <= wait_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      pass3_q     <= pass3_d;
      grade_q     <= grade_d;
      attempts_q  <= attempts_d;
      score_q     <= score_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign pass3     = pass3_q;
  assign grade     = grade_q;
  assign attempts  = attempts_q;
  assign score     = score_q;

endmodule
`default_nettype wire

// File: tb/tb_stage3.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage3
// Brief    : Randomized bench for stage3 against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage3;

  localparam int PASS_TH    = 75;
  localparam int MAX_RETRY  = 2;
  localparam int RETRY_WAIT = 3;
`ifdef STAGE3_BURNOUT_EN
  localparam bit BURNOUT = 1'b1;
`else
  localparam bit BURNOUT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       pass2;
  logic [1:0] bonus2;
  logic [6:0] effort;
  logic [4:0] hard;
  logic [6:0] random3;
  logic       out_valid;
  logic       out_ready;
  logic       pass3;
  logic [1:0] grade;
  logic [1:0] attempts;
  logic [6:0] score;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  int exp_in_ready, exp_out_valid, exp_pass3, exp_grade, exp_attempts, exp_score;

  stage3 #(
    .PASS_TH   (PASS_TH),
    .MAX_RETRY (MAX_RETRY),
    .RETRY_WAIT(RETRY_WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pass2    (pass2),
    .bonus2   (bonus2),
    .effort   (effort),
    .hard     (hard),
    .random3  (random3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pass3    (pass3),
    .grade    (grade),
    .attempts (attempts),
    .score    (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-transaction outcome; rnd holds the random3 value seen at each EVAL.
  function automatic void model(input bit p2, input int b, input int e0, input int h,
                                input logic [20:0] rnd, output int mp, output int mg,
                                output int ma, output int ms, output int lat);
    int e, raw, s, nxt;
    logic [6:0] r;
    bit done;
    mp = 0; mg = 0; ma = 0; ms = 0; lat = 1;
    if (!p2) return;
    e = e0; lat = 2; done = 1'b0;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      if (!done) begin
        raw = e + 4 * b - h;
        s   = (raw < 0) ? 0 : ((raw > 127) ? 127 : raw);
        r   = rnd[7*a +: 7];
        ms  = s;
        ma  = a;
        if (BURNOUT && e > 100 && r[6:5] == 2'b00) begin
          done = 1'b1;
        end else if (s >= PASS_TH) begin
          mp   = 1;
          mg   = (s > 94) ? 3 : (s > 87) ? 2 : (s > 80) ? 1 : 0;
          done = 1'b1;
        end else if (a < MAX_RETRY) begin
          nxt = e + int'(r[2:0]) + 1;
          e   = (nxt > 127) ? 127 : nxt;
          lat += RETRY_WAIT + 1;
        end else begin
          done = 1'b1;
        end
      end
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk(input bit busy_v);
    in_valid = busy_v ? 1'b1 : 1'($urandom);
    pass2    = 1'($urandom);
    bonus2   = 2'($urandom);
    effort   = 7'($urandom);
    hard     = 5'($urandom);
    random3  = 7'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      exp_in_ready = 1; exp_out_valid = 0;
      drive_junk(1'b0);
      in_valid  = 1'b0;
      out_ready = 1'($urandom);
    end
  endtask

  task automatic run_txn(input bit p2, input int b, input int e, input int h,
                         input logic [20:0] rnd, input int hold, input bit busy_v);
    int mp, mg, ma, ms, lat;
    model(p2, b, e, h, rnd, mp, mg, ma, ms, lat);
    next_cycle();
    exp_in_ready = 1; exp_out_valid = 0;
    in_valid = 1'b1; pass2 = p2; bonus2 = 2'(b); effort = 7'(e); hard = 5'(h);
    random3 = 7'($urandom); out_ready = 1'($urandom);
    for (int c = 1; c < lat; c++) begin
      next_cycle();
      exp_in_ready = 0; exp_out_valid = 0;
      drive_junk(busy_v);
      if ((c - 1) % (RETRY_WAIT + 1) == 0)
        random3 = rnd[7*((c - 1) / (RETRY_WAIT + 1)) +: 7];
      out_ready = 1'($urandom);
    end
    for (int k = 0; k <= hold; k++) begin
      next_cycle();
      exp_in_ready = 0; exp_out_valid = 1;
      exp_pass3 = mp; exp_grade = mg; exp_attempts = ma; exp_score = ms;
      drive_junk(busy_v);
      out_ready = (k == hold);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready", int'(in_ready), exp_in_ready);
        chk("out_valid", int'(out_valid), exp_out_valid);
        if (exp_out_valid != 0) begin
          chk("pass3", int'(pass3), exp_pass3);
          chk("grade", int'(grade), exp_grade);
          chk("attempts", int'(attempts), exp_attempts);
          chk("score", int'(score), exp_score);
        end
      end
    end
  end

  initial begin
    int mp, mg, ma, ms, lat;
    rst = 1'b1; in_valid = 1'b0; pass2 = 1'b0; bonus2 = 2'd0; effort = 7'd0;
    hard = 5'd0; random3 = 7'd0; out_ready = 1'b0;
    exp_in_ready = 1; exp_out_valid = 0;
    exp_pass3 = 0; exp_grade = 0; exp_attempts = 0; exp_score = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_pass3", int'(pass3), 0);
    chk("reset_grade", int'(grade), 0);
    chk("reset_attempts", int'(attempts), 0);
    chk("reset_score", int'(score), 0);

    // Hand-computed pins for the model itself
    model(1'b1, 2, 90, 5, 21'd0, mp, mg, ma, ms, lat);
    chk("pin_a_score", ms, 93); chk("pin_a_grade", mg, 2); chk("pin_a_lat", lat, 2);
    model(1'b1, 0, 70, 4, {7'd0, 7'd0, 7'd7}, mp, mg, ma, ms, lat);
    chk("pin_b_score", ms, 75); chk("pin_b_pass", mp, 1);
    chk("pin_b_attempts", ma, 2); chk("pin_b_lat", lat, 10);
    model(1'b1, 0, 20, 31, 21'd0, mp, mg, ma, ms, lat);
    chk("pin_c_score", ms, 0); chk("pin_c_pass", mp, 0); chk("pin_c_attempts", ma, 2);
    model(1'b0, 3, 127, 0, 21'd0, mp, mg, ma, ms, lat);
    chk("pin_d_lat", lat, 1); chk("pin_d_score", ms, 0);
    model(1'b1, 0, 110, 0, 21'd0, mp, mg, ma, ms, lat);
    chk("pin_e_pass", mp, BURNOUT ? 0 : 1); chk("pin_e_score", ms, 110);

    rst = 1'b0;
    chk_en = 1'b1;

    run_txn(1'b0, 3, 100, 0, 21'($urandom), 1, 1'b0);
    run_txn(1'b1, 2, 90, 5, 21'd0, 0, 1'b0);
    run_txn(1'b1, 0, 70, 4, {7'd0, 7'd0, 7'd7}, 0, 1'b0);
    run_txn(1'b1, 0, 20, 31, 21'd0, 0, 1'b0);
    run_txn(1'b1, 2, 90, 5, 21'd0, 5, 1'b1);
    run_txn(1'b1, 1, 60, 10, 21'($urandom), 2, 1'b1);
    idle(1);

    // Asynchronous reset in the middle of the second retry window
    next_cycle();
    exp_in_ready = 1; exp_out_valid = 0;
    in_valid = 1'b1; pass2 = 1'b1; bonus2 = 2'd0; effort = 7'd20; hard = 5'd31;
    random3 = 7'd0; out_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      exp_in_ready = 0; exp_out_valid = 0;
      drive_junk(1'b1);
    end
    chk("attempts_mid_retry", int'(attempts), 1);
    next_cycle();
    rst = 1'b1;
    exp_in_ready = 1; exp_out_valid = 0;
    drive_junk(1'b1);
    #1;
    chk("rst_attempts", int'(attempts), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    in_valid = 1'b0;

    run_txn(1'b1, 2, 90, 5, 21'd0, 0, 1'b0);
`ifdef STAGE3_BURNOUT_EN
    run_txn(1'b1, 0, 110, 0, 21'd0, 0, 1'b0);
`endif

    for (int t = 0; t < 150; t++) begin
      idle(int'($urandom_range(0, 2)));
      run_txn($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
              21'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end
    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
